// File: rtl/hs_pkg.sv
// Shared constants and types for the handshake round-robin arbiter.
// The lock-state enum is only consumed when HS_ARB_PKT_LOCK_EN is defined.
package hs_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 8;

  // Width of an index into NUM_REQ requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module hs_rr_pick
  import hs_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  logic [ID_W-1:0] cand [NUM_REQ];

  // cand[k] is the requester visited k steps after ptr.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = ID_W'((int'(ptr) + gi) % NUM_REQ);
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand[k]]) begin
        winner = cand[k];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Valid/ready round-robin arbiter with a registered output stage.
// Define HS_ARB_PKT_LOCK_EN to add LAST_UP/LAST_DOWN and packet locking.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int WIDTH   = DEFAULT_WIDTH,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_REQ-1:0]       VALID_UP,
  output logic [NUM_REQ-1:0]       READY_UP,
  input  logic [NUM_REQ*WIDTH-1:0] DATA_UP,
  output logic                     VALID_DOWN,
  input  logic                     READY_DOWN,
  output logic [WIDTH-1:0]         DATA_DOWN,
  output logic [ID_W-1:0]          GRANT_ID
`ifdef HS_ARB_PKT_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]       LAST_UP,
  output logic                     LAST_DOWN
`endif
);

  logic             valid_down_reg;
  logic [WIDTH-1:0] data_down_reg;
  logic [ID_W-1:0]  grant_id_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  ptr_next;

  logic             accept;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             transfer;
  logic             ptr_adv;

  logic [WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = DATA_UP[gi*WIDTH +: WIDTH];
  end

  hs_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (VALID_UP),
    .ptr    (ptr_reg),
    .winner (pick_id),
    .found  (pick_found)
  );

  assign accept   = READY_DOWN || !valid_down_reg;
  // The winner may be a forced lock owner that is not currently valid.
  assign transfer = accept && win_found && VALID_UP[win_id];
  assign ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign READY_UP[gi] = accept && win_found && (win_id == ID_W'(gi));
  end

`ifdef HS_ARB_PKT_LOCK_EN
  lock_state_t     lock_state_reg;
  lock_state_t     lock_state_next;
  logic [ID_W-1:0] lock_id_reg;
  logic [ID_W-1:0] lock_id_next;
  logic            last_down_reg;

  always_comb begin
    win_id    = pick_id;
    win_found = pick_found;
    if (lock_state_reg == LOCKED) begin
      win_id    = lock_id_reg;
      win_found = 1'b1;
    end
  end

  assign ptr_adv = transfer && LAST_UP[win_id];

  always_comb begin
    lock_state_next = lock_state_reg;
    lock_id_next    = lock_id_reg;
    case (lock_state_reg)
      UNLOCKED: begin
        if (transfer && !LAST_UP[win_id]) begin
          lock_state_next = LOCKED;
          lock_id_next    = win_id;
        end
      end
      LOCKED: begin
        if (transfer && LAST_UP[win_id]) begin
          lock_state_next = UNLOCKED;
        end
      end
      default: lock_state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_state_reg <= UNLOCKED;
      lock_id_reg    <= '0;
      last_down_reg  <= 1'b0;
    end else begin
      lock_state_reg <= lock_state_next;
      lock_id_reg    <= lock_id_next;
      if (transfer) begin
        last_down_reg <= LAST_UP[win_id];
      end
    end
  end

  assign LAST_DOWN = last_down_reg;
`else
  assign win_id    = pick_id;
  assign win_found = pick_found;
  assign ptr_adv   = transfer;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_down_reg <= 1'b0;
      data_down_reg  <= '0;
      grant_id_reg   <= '0;
      ptr_reg        <= '0;
    end else begin
      if (accept) begin
        valid_down_reg <= transfer;
        if (transfer) begin
          data_down_reg <= data_arr[win_id];
          grant_id_reg  <= win_id;
        end
      end
      if (ptr_adv) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign VALID_DOWN = valid_down_reg;
  assign DATA_DOWN  = data_down_reg;
  assign GRANT_ID   = grant_id_reg;

endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of upstream requesters (2..16).
REQ-002 Parameter: WIDTH, default 8, payload width per requester.
REQ-003 Port: CLK  input  1  clock; all state updates on the rising edge.
REQ-004 Port: RESET  input  1  synchronous, active-high reset.
REQ-005 Port: VALID_UP  input  NUM_REQ  per-requester valid.
REQ-006 Port: READY_UP  output  NUM_REQ  per-requester ready, one-hot or zero.
REQ-007 Port: DATA_UP  input  NUM_REQ*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: VALID_DOWN  output  1  registered downstream valid.
REQ-009 Port: READY_DOWN  input  1  downstream ready.
REQ-010 Port: DATA_DOWN  output  WIDTH  registered downstream payload.
REQ-011 Port: GRANT_ID  output  clog2(NUM_REQ)  registered index of the requester that sourced DATA_DOWN.

Function
REQ-012 The block SHALL compute accept = READY_DOWN || !VALID_DOWN combinationally.
REQ-013 The block SHALL select the winner combinationally: the first requester with VALID_UP=1, searching from pointer PTR upward and wrapping modulo NUM_REQ.
REQ-014 READY_UP[w] SHALL equal accept for winner w; every other READY_UP bit SHALL be 0; all bits SHALL be 0 when no VALID_UP is set.
REQ-015 On a transfer (accept with a winner), the block SHALL load VALID_DOWN=1, DATA_DOWN=DATA_UP[w], and GRANT_ID=w at the next edge, giving a latency of 1 cycle.
REQ-016 On accept with no winner, the block SHALL load VALID_DOWN=0 and hold DATA_DOWN and GRANT_ID.
REQ-017 When accept=0 (VALID_DOWN=1, READY_DOWN=0), all outputs SHALL hold and no READY_UP bit SHALL assert.
REQ-018 On a transfer, PTR SHALL update to (w+1) mod NUM_REQ; otherwise PTR SHALL hold.
REQ-019 Simultaneous drain and refill in one cycle SHALL be supported, giving sustained throughput of 1 transfer per cycle.
REQ-020 A requester that keeps VALID_UP asserted SHALL be granted within NUM_REQ transfers (starvation-free).

Reset
REQ-021 While RESET=1, the block SHALL clear VALID_DOWN=0, DATA_DOWN=0, GRANT_ID=0, PTR=0, and, when configured, the lock state to UNLOCKED.
REQ-022 Reset SHALL take priority over any transfer in the same cycle, and reset mid-packet SHALL discard any lock.
REQ-023 In the first cycle after reset is released, requester 0 SHALL hold highest priority.

Configuration
REQ-024 With macro HS_ARB_PKT_LOCK_EN defined, the block SHALL add input LAST_UP [NUM_REQ] and output LAST_DOWN [1], registered alongside DATA_DOWN.
REQ-025 With HS_ARB_PKT_LOCK_EN defined, the lock FSM SHALL behave as follows:
- UNLOCKED -> LOCKED on a transfer with LAST_UP[w]=0, recording w.
- LOCKED -> UNLOCKED on a transfer from the locked requester with LAST_UP=1.
- While LOCKED, only the locked requester SHALL win, even if its VALID_UP is low; others SHALL stall.
- PTR SHALL update only on the transfer that carries LAST.
REQ-026 Without HS_ARB_PKT_LOCK_EN, no LAST ports or lock state SHALL exist, and every transfer SHALL be an independent arbitration.

Structure
REQ-027 Shared package hs_pkg SHALL hold:
- default NUM_REQ and WIDTH constants;
- the lock-state enum (UNLOCKED, LOCKED);
- a clog2-width helper constant for GRANT_ID.
REQ-028 Sub-module hs_rr_pick SHALL be the combinational round-robin priority picker (inputs: request vector, PTR; outputs: winner index, found flag), instantiated once.

Verification
REQ-029 All four requesters continuously valid, READY_DOWN=1 -> GRANT_ID sequence 0,1,2,3,0,1 on consecutive cycles after the first, with VALID_DOWN held at 1.
REQ-030 VALID_UP=4'b1010, PTR=0 -> requester 1 granted, then 3, then 1; READY_UP bits 0 and 2 are never asserted.
REQ-031 Output full, READY_DOWN=0 for 5 cycles with VALID_UP=4'b1111 -> READY_UP=0 and DATA_DOWN/GRANT_ID stable for 5 cycles; resume on the first cycle READY_DOWN=1.
REQ-032 RESET asserted with VALID_DOWN=1 and PTR=2 -> next cycle VALID_DOWN=0, DATA_DOWN=0, GRANT_ID=0; first grant after release goes to the lowest valid index.
REQ-033 HS_ARB_PKT_LOCK_EN: requester 2 sends a 3-beat packet (LAST on beat 3) while requester 0 is valid -> GRANT_ID 2,2,2 then 0; requester 0 stalls during a 1-cycle VALID_UP[2] gap.
